// File: rtl/scie_pkg.sv
// Shared definitions for the SCIE complex FIR accelerator: custom opcodes,
// the complex accumulator container and the MAC sequencer state encoding.
package scie_pkg;

    localparam logic [6:0] OP_LOAD = 7'h0B;
    localparam logic [6:0] OP_PUSH = 7'h2B;
    localparam logic [6:0] OP_READ = 7'h5B;
    localparam logic [6:0] OP_CLR  = 7'h7B;

    // Widest accumulator a complex result may carry between blocks (ACC_W < CPLX_W)
    localparam int unsigned CPLX_W = 64;

    typedef struct packed {
        logic signed [CPLX_W-1:0] re;
        logic signed [CPLX_W-1:0] im;
    } cplx_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MAC,
        ST_DONE
    } state_t;

endpackage

// File: rtl/scie_cmac.sv
// LANES-wide complex multiply-accumulate: lane products are summed and
// registered, then folded into the accumulator on the following step.
// 'sum' always shows the accumulator plus any product still in the register.
module scie_cmac
    import scie_pkg::*;
#(
    parameter int unsigned LANES  = 2,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ACC_W  = 40
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic                         en,
    input  logic [LANES-1:0][DATA_W-1:0] c_re,
    input  logic [LANES-1:0][DATA_W-1:0] c_im,
    input  logic [LANES-1:0][DATA_W-1:0] x_re,
    input  logic [LANES-1:0][DATA_W-1:0] x_im,
    output cplx_t                        sum
);

    localparam int unsigned PW = 2 * DATA_W + 1;

    logic signed [ACC_W-1:0] prod_re_d, prod_im_d;
    logic signed [ACC_W-1:0] prod_re_q, prod_im_q;
    logic signed [ACC_W-1:0] acc_re_q, acc_im_q;
    logic signed [ACC_W-1:0] tot_re, tot_im;
    logic                    prod_vld_q;

    // Complex products of all lanes, summed per component
    always_comb begin
        logic signed [PW-1:0] cr, ci, xr, xi, p_re, p_im;
        cr = '0; ci = '0; xr = '0; xi = '0; p_re = '0; p_im = '0;
        prod_re_d = '0;
        prod_im_d = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            cr   = {{(PW-DATA_W){c_re[l][DATA_W-1]}}, c_re[l]};
            ci   = {{(PW-DATA_W){c_im[l][DATA_W-1]}}, c_im[l]};
            xr   = {{(PW-DATA_W){x_re[l][DATA_W-1]}}, x_re[l]};
            xi   = {{(PW-DATA_W){x_im[l][DATA_W-1]}}, x_im[l]};
            p_re = cr * xr - ci * xi;
            p_im = cr * xi + ci * xr;
            prod_re_d = prod_re_d + {{(ACC_W-PW){p_re[PW-1]}}, p_re};
            prod_im_d = prod_im_d + {{(ACC_W-PW){p_im[PW-1]}}, p_im};
        end
    end

    // Product register and accumulator; clear starts a new computation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_re_q  <= '0;
            prod_im_q  <= '0;
            acc_re_q   <= '0;
            acc_im_q   <= '0;
            prod_vld_q <= 1'b0;
        end else if (clear) begin
            acc_re_q   <= '0;
            acc_im_q   <= '0;
            prod_vld_q <= 1'b0;
        end else if (en) begin
            prod_re_q  <= prod_re_d;
            prod_im_q  <= prod_im_d;
            prod_vld_q <= 1'b1;
            acc_re_q   <= acc_re_q + (prod_vld_q ? prod_re_q : '0);
            acc_im_q   <= acc_im_q + (prod_vld_q ? prod_im_q : '0);
        end
    end

    // Running total including the last registered product
    always_comb begin
        tot_re = acc_re_q + (prod_vld_q ? prod_re_q : '0);
        tot_im = acc_im_q + (prod_vld_q ? prod_im_q : '0);
        sum.re = {{(CPLX_W-ACC_W){tot_re[ACC_W-1]}}, tot_re};
        sum.im = {{(CPLX_W-ACC_W){tot_im[ACC_W-1]}}, tot_im};
    end

endmodule

// File: rtl/scie_cfir_serial.sv
// SCIE complex FIR accelerator: coefficient RF, per-channel sample
// histories, time-multiplexed MAC sequencer, output scaling and handshake.
module scie_cfir_serial
    import scie_pkg::*;
#(
    parameter int unsigned TAPS      = 8,
    parameter int unsigned CHANNELS  = 2,
    parameter int unsigned LANES     = 2,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned ACC_W     = 40,
    parameter int unsigned OUT_SHIFT = 0,
    parameter int unsigned SAT       = 0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     io_valid,
    output logic                     io_ready,
    input  logic [31:0]              io_insn,
    input  logic signed [DATA_W-1:0] io_rs1_real,
    input  logic signed [DATA_W-1:0] io_rs1_imag,
    input  logic [31:0]              io_rs2,
    output logic                     io_rd_valid,
    output logic signed [DATA_W-1:0] io_rd_real,
    output logic signed [DATA_W-1:0] io_rd_imag
);

    localparam int unsigned STEPS  = TAPS / LANES;
    localparam int unsigned STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int unsigned TAP_W  = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int unsigned CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MINV = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    logic signed [DATA_W-1:0] coef_re [TAPS];
    logic signed [DATA_W-1:0] coef_im [TAPS];
    logic signed [DATA_W-1:0] hist_re [CHANNELS][TAPS];
    logic signed [DATA_W-1:0] hist_im [CHANNELS][TAPS];
    logic signed [DATA_W-1:0] y_re    [CHANNELS];
    logic signed [DATA_W-1:0] y_im    [CHANNELS];

    state_t                   state_q, state_d;
    logic [STEP_W-1:0]        step_q;
    logic [CH_W-1:0]          ch_q;
    logic                     mac_en, mac_done;

    logic [LANES-1:0][DATA_W-1:0] lane_c_re, lane_c_im, lane_x_re, lane_x_im;
    cplx_t                    mac_sum;
    logic signed [ACC_W-1:0]  acc_re, acc_im;
    logic signed [DATA_W-1:0] y_new_re, y_new_im;
    logic                     unused_bits;

    logic [6:0]               opcode;
    logic                     accept, do_load, do_push, do_read, do_clr;
    logic [TAP_W-1:0]         tap_idx;
    logic [CH_W-1:0]          ch_idx;

    // Instruction decode; out-of-range indices fold back modulo the array size
    always_comb begin
        opcode  = io_insn[6:0];
        accept  = io_valid & io_ready;
        do_load = accept && (opcode == OP_LOAD);
        do_push = accept && (opcode == OP_PUSH);
        do_read = accept && (opcode == OP_READ);
        do_clr  = accept && (opcode == OP_CLR);
        tap_idx = TAP_W'(io_rs2 % TAPS);
        ch_idx  = CH_W'(io_rs2 % CHANNELS);
    end

    assign unused_bits = ^{io_insn[31:7], mac_sum.re[CPLX_W-1:ACC_W], mac_sum.im[CPLX_W-1:ACC_W]};

    // Sequencer state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Sequencer next state: one PUSH runs STEPS MAC cycles then one DONE cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (do_push) state_d = ST_MAC;
            ST_MAC:  if (step_q == STEP_W'(STEPS - 1)) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Sequencer outputs; all instructions stall while a computation is in flight
    always_comb begin
        io_ready = (state_q == ST_IDLE);
        mac_en   = (state_q == ST_MAC);
        mac_done = (state_q == ST_DONE);
    end

    // Route the current tap group of the active channel onto the MAC lanes
    always_comb begin
        logic [TAP_W-1:0] tap;
        tap = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            tap          = TAP_W'(32'(step_q) * LANES + l);
            lane_c_re[l] = coef_re[tap];
            lane_c_im[l] = coef_im[tap];
            lane_x_re[l] = hist_re[ch_q][tap];
            lane_x_im[l] = hist_im[ch_q][tap];
        end
    end

    scie_cmac #(
        .LANES  (LANES),
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_cmac (
        .clk   (clock),
        .rst_n (reset),
        .clear (do_push),
        .en    (mac_en),
        .c_re  (lane_c_re),
        .c_im  (lane_c_im),
        .x_re  (lane_x_re),
        .x_im  (lane_x_im),
        .sum   (mac_sum)
    );

    function automatic logic signed [DATA_W-1:0] fmt(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] s;
        s = a >>> OUT_SHIFT;
        if (SAT != 0 && s > MAXV)      fmt = MAXV[DATA_W-1:0];
        else if (SAT != 0 && s < MINV) fmt = MINV[DATA_W-1:0];
        else                           fmt = s[DATA_W-1:0];
    endfunction

    // Scale and wrap/saturate the finished accumulator
    always_comb begin
        acc_re   = mac_sum.re[ACC_W-1:0];
        acc_im   = mac_sum.im[ACC_W-1:0];
        y_new_re = fmt(acc_re);
        y_new_im = fmt(acc_im);
    end

    // Architectural state: coefficients, histories, results and READ port
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned k = 0; k < TAPS; k++) begin
                coef_re[k] <= '0;
                coef_im[k] <= '0;
            end
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                for (int unsigned k = 0; k < TAPS; k++) begin
                    hist_re[c][k] <= '0;
                    hist_im[c][k] <= '0;
                end
                y_re[c] <= '0;
                y_im[c] <= '0;
            end
            step_q      <= '0;
            ch_q        <= '0;
            io_rd_valid <= 1'b0;
            io_rd_real  <= '0;
            io_rd_imag  <= '0;
        end else begin
            io_rd_valid <= do_read;
            if (do_load) begin
                coef_re[tap_idx] <= io_rs1_real;
                coef_im[tap_idx] <= io_rs1_imag;
            end
            if (do_push) begin
                hist_re[ch_idx][0] <= io_rs1_real;
                hist_im[ch_idx][0] <= io_rs1_imag;
                for (int unsigned k = 1; k < TAPS; k++) begin
                    hist_re[ch_idx][k] <= hist_re[ch_idx][k-1];
                    hist_im[ch_idx][k] <= hist_im[ch_idx][k-1];
                end
                ch_q   <= ch_idx;
                step_q <= '0;
            end
            if (do_clr) begin
                for (int unsigned k = 0; k < TAPS; k++) begin
                    hist_re[ch_idx][k] <= '0;
                    hist_im[ch_idx][k] <= '0;
                end
                y_re[ch_idx] <= '0;
                y_im[ch_idx] <= '0;
            end
            if (do_read) begin
                io_rd_real <= y_re[ch_idx];
                io_rd_imag <= y_im[ch_idx];
            end
            if (mac_en) step_q <= step_q + 1'b1;
            if (mac_done) begin
                y_re[ch_q] <= y_new_re;
                y_im[ch_q] <= y_new_im;
            end
        end
    end

endmodule

// File: tb/tb_scie_cfir_serial.sv
// Directed bench for scie_cfir_serial: two instances (wrap and saturate)
// share one instruction stream; expected values are hand-computed.
module tb_scie_cfir_serial;
    import scie_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        io_valid;
    logic [31:0] io_insn;
    logic [15:0] io_rs1_real, io_rs1_imag;
    logic [31:0] io_rs2;

    logic        ready_a, rdv_a, ready_b, rdv_b;
    logic [15:0] rdr_a, rdi_a, rdr_b, rdi_b;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    scie_cfir_serial #(
        .TAPS(5), .CHANNELS(2), .LANES(1), .DATA_W(16), .ACC_W(40), .OUT_SHIFT(0), .SAT(0)
    ) u_dut (
        .clock(clock), .reset(reset), .io_valid(io_valid), .io_ready(ready_a),
        .io_insn(io_insn), .io_rs1_real(io_rs1_real), .io_rs1_imag(io_rs1_imag),
        .io_rs2(io_rs2), .io_rd_valid(rdv_a), .io_rd_real(rdr_a), .io_rd_imag(rdi_a)
    );

    scie_cfir_serial #(
        .TAPS(5), .CHANNELS(2), .LANES(1), .DATA_W(16), .ACC_W(40), .OUT_SHIFT(0), .SAT(1)
    ) u_sat (
        .clock(clock), .reset(reset), .io_valid(io_valid), .io_ready(ready_b),
        .io_insn(io_insn), .io_rs1_real(io_rs1_real), .io_rs1_imag(io_rs1_imag),
        .io_rs2(io_rs2), .io_rd_valid(rdv_b), .io_rd_real(rdr_b), .io_rd_imag(rdi_b)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input int exp);
        logic [15:0] e;
        e = 16'(exp);
        n_assert++;
        assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, $signed(obs), $signed(e));
        end
    endtask

    // Present one instruction and hold it until accepted; returns stall cycles
    task automatic issue(input logic [6:0] op, input int re, input int im, input int r2,
                         output int waits);
        waits = 0;
        @(negedge clock);
        io_valid    = 1'b1;
        io_insn     = {25'd0, op};
        io_rs1_real = 16'(re);
        io_rs1_imag = 16'(im);
        io_rs2      = 32'(r2);
        while (!ready_a && waits < 100) begin
            @(negedge clock);
            waits++;
        end
        if (waits >= 100) chk("accept_timeout", 16'(waits), 0);
        @(posedge clock);
        #1 io_valid = 1'b0;
    endtask

    // PUSH and confirm the engine stays busy for 5 MAC cycles + 1 DONE cycle
    task automatic push(input int ch, input int re, input int im, input string tag);
        int w, cnt;
        issue(OP_PUSH, re, im, ch, w);
        cnt = 0;
        @(negedge clock);
        while (!ready_a && cnt < 100) begin
            cnt++;
            @(negedge clock);
        end
        chk({tag, "_busy"}, 16'(cnt), 6);
    endtask

    task automatic rd_result(input int ar, input int ai, input int br, input int bi,
                             input string tag);
        @(negedge clock);
        chk({tag, "_vld_a"}, {15'd0, rdv_a}, 1);
        chk({tag, "_vld_b"}, {15'd0, rdv_b}, 1);
        chk({tag, "_re_a"}, rdr_a, ar);
        chk({tag, "_im_a"}, rdi_a, ai);
        chk({tag, "_re_b"}, rdr_b, br);
        chk({tag, "_im_b"}, rdi_b, bi);
    endtask

    task automatic read(input int ch, input int er, input int ei, input string tag);
        int w;
        issue(OP_READ, 0, 0, ch, w);
        rd_result(er, ei, er, ei, tag);
    endtask

    int w;

    initial begin
        reset = 1'b0; io_valid = 1'b0; io_insn = '0;
        io_rs1_real = '0; io_rs1_imag = '0; io_rs2 = '0;
        repeat (2) @(negedge clock);
        chk("rst_ready_a", {15'd0, ready_a}, 1);
        chk("rst_ready_b", {15'd0, ready_b}, 1);
        chk("rst_rdv", {15'd0, rdv_a}, 0);
        chk("rst_rdr", rdr_a, 0);
        chk("rst_rdi", rdi_a, 0);
        reset = 1'b1;

        issue(OP_LOAD,   2,  42, 0, w);
        issue(OP_LOAD, -29, -21, 1, w);
        issue(OP_LOAD,  13,  33, 2, w);
        issue(OP_LOAD, -25, -46, 3, w);
        issue(OP_LOAD, -49, -37, 4, w);
        chk("load_ready", {15'd0, ready_a}, 1);

        // (2+42j)(1-12j) = 506+18j
        push(0, 1, -12, "p0a");
        read(0, 506, 18, "r0a");
        @(negedge clock);
        chk("rdv_pulse_end", {15'd0, rdv_a}, 0);

        // + (2+42j)(40+17j) + (-29-21j)(1-12j) = -915+2041j
        push(0, 40, 17, "p0b");
        read(0, -915, 2041, "r0b");

        push(1, 1, -12, "p1a");
        read(1, 506, 18, "r1a");
        read(0, -915, 2041, "r0c");

        // READ presented while the engine runs: stalls until DONE retires
        issue(OP_PUSH, 40, 17, 1, w);
        issue(OP_READ, 0, 0, 1, w);
        chk("busy_read_stall", 16'(w), 6);
        rd_result(-915, 2041, -915, 2041, "r1b");
        read(3, -915, 2041, "r_wrap");

        issue(7'h13, 7, 7, 0, w);
        @(negedge clock);
        chk("noop_rdv", {15'd0, rdv_a}, 0);
        chk("noop_ready", {15'd0, ready_a}, 1);

        issue(OP_CLR, 0, 0, 0, w);
        read(0, 0, 0, "r_clr");
        push(0, 1, -12, "p0c");
        read(0, 506, 18, "r0d");

        // 32767*32767 = 0x3FFF0001: wraps to 1, saturates to 32767
        issue(OP_LOAD, 32767, 0, 0, w);
        for (int k = 1; k < 5; k++) issue(OP_LOAD, 0, 0, k, w);
        issue(OP_CLR, 0, 0, 0, w);
        push(0, 32767, 0, "p_sat");
        issue(OP_READ, 0, 0, 0, w);
        rd_result(1, 0, 32767, 0, "r_sat");

        // Reset in the middle of a computation
        issue(OP_PUSH, 5, 5, 1, w);
        repeat (2) @(negedge clock);
        chk("mid_busy", {15'd0, ready_a}, 0);
        reset = 1'b0;
        #1;
        chk("mid_rst_ready_a", {15'd0, ready_a}, 1);
        chk("mid_rst_ready_b", {15'd0, ready_b}, 1);
        chk("mid_rst_rdr_a", rdr_a, 0);
        chk("mid_rst_rdr_b", rdr_b, 0);
        chk("mid_rst_rdi", rdi_a, 0);
        @(negedge clock);
        reset = 1'b1;
        read(0, 0, 0, "r_post_rst0");
        read(1, 0, 0, "r_post_rst1");
        push(0, 1, -12, "p_post_rst");
        read(0, 0, 0, "r_coef_cleared");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d assertions evaluated", n_assert);
        $fatal(1, "watchdog");
    end

endmodule
